// File: rtl/branch_predictor.sv
// Bimodal / gshare 2-bit branch predictor; BP_GSHARE_EN selects gshare (PC XOR global history) indexing.
// Zero-latency combinational prediction, one-edge update latency; no backpressure, one update accepted per cycle.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       cnt_q [ENTRIES];
  logic [1:0]       cnt_d [ENTRIES];
  logic [1:0]       upd_cur;
  logic [IDX_W-1:0] base_idx;
  logic             unused_pc_bits;

  assign base_idx = pred_pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  if (GHR_W > IDX_W) begin : g_ghr_too_wide
    $error("GHR_W must not exceed IDX_W");
  end

  assign pred_idx = base_idx ^ IDX_W'(ghr_q);

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) begin
      ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};
`else
  assign pred_idx = base_idx;
  // History width is meaningless without gshare indexing.
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], (GHR_W > IDX_W)};
`endif

  // Read is from the registered table only, so a same-cycle update is not bypassed.
  assign pred_taken = cnt_q[pred_idx][1];
  assign mispredict = upd_valid & (upd_taken ^ upd_pred);

  assign upd_cur = cnt_q[upd_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid) begin
      if (upd_taken) begin
        if (upd_cur != 2'b11) cnt_d[upd_idx] = upd_cur + 2'd1;
      end else begin
        if (upd_cur != 2'b00) cnt_d[upd_idx] = upd_cur - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.IDX_W(6), .GHR_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .pred_idx   (pred_idx),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .upd_pred   (upd_pred),
    .mispredict (mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [4];
    pcs[0] = 32'h0000_0040; pcs[1] = 32'h0000_0000;
    pcs[2] = 32'h0000_00FC; pcs[3] = 32'hDEAD_BEEF;
    upd_valid = 1'b0;
    do_reset();
    pred_pc = 32'h0000_0040;
    #1;
    checks++;
    if (pred_idx !== 6'h10) begin
      errors++;
      $display("FAIL reset_idx: got %h expected %h", pred_idx, 6'h10);
    end
    for (int i = 0; i < 4; i++) begin
      pred_pc = pcs[i];
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
        errors++;
        $display("FAIL reset_taken pc=%h: got %b expected 0", pcs[i], pred_taken);
      end
    end
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL reset_mispredict: got %b expected 0", mispredict);
    end
  endtask

  // Three taken updates (01->10->11->11), then two not-taken (11->10->01).
  task automatic test_saturate_up();
    logic exp_seq [5];
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1;
    exp_seq[3] = 1'b1; exp_seq[4] = 1'b0;
    pred_pc = 32'h0000_0040;
    upd_idx = 6'h10;
    upd_pred = 1'b0;
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'b1;
      upd_taken = (i < 3);
      step();
      upd_valid = 1'b0;
      #1;
      checks++;
      if (pred_taken !== exp_seq[i]) begin
        errors++;
        $display("FAIL sat_up step%0d: got %b expected %b", i, pred_taken, exp_seq[i]);
      end
    end
  endtask

  // Four not-taken saturate at 00; two taken then go 01 (pred 0) and 10 (pred 1).
  task automatic test_saturate_down();
    logic exp_seq [6];
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0;
    exp_seq[3] = 1'b0; exp_seq[4] = 1'b0; exp_seq[5] = 1'b1;
    pred_pc = 32'h0000_0080;
    upd_idx = 6'h20;
    upd_pred = 1'b0;
    for (int i = 0; i < 6; i++) begin
      upd_valid = 1'b1;
      upd_taken = (i >= 4);
      step();
      upd_valid = 1'b0;
      #1;
      checks++;
      if (pred_taken !== exp_seq[i]) begin
        errors++;
        $display("FAIL sat_down step%0d: got %b expected %b", i, pred_taken, exp_seq[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    pred_pc = 32'h0000_0014;
    upd_valid = 1'b1;
    upd_idx = 6'h05;
    upd_taken = 1'b1;
    upd_pred = 1'b0;
    #1;
    checks++;
    if (pred_idx !== 6'h05 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_before: idx=%h taken=%b expected idx=05 taken=0", pred_idx, pred_taken);
    end
    step();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_after: got %b expected 1", pred_taken);
    end
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic       exp;
      v = 3'(i);
      upd_valid = v[2];
      upd_taken = v[1];
      upd_pred  = v[0];
      upd_idx   = 6'h3A;
      exp = v[2] & (v[1] ^ v[0]);
      #1;
      checks++;
      if (mispredict !== exp) begin
        errors++;
        $display("FAIL mispredict v=%b t=%b p=%b: got %b expected %b", v[2], v[1], v[0], mispredict, exp);
      end
    end
    upd_valid = 1'b0;
    step();
  endtask

  task automatic test_no_update();
    pred_pc = 32'h0000_00C4;
    upd_valid = 1'b0;
    upd_idx = 6'h31;
    upd_taken = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL no_update: got %b expected 0", pred_taken);
    end
  endtask

  task automatic test_reset_discard();
    pred_pc = 32'h0000_00C0;
    upd_idx = 6'h30;
    upd_taken = 1'b1;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL discard_setup: got %b expected 1", pred_taken);
    end
    upd_valid = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got %b expected 0", pred_taken);
    end
    pred_pc = 32'h0000_0040;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_0x10: got %b expected 0", pred_taken);
    end
  endtask

`ifdef BP_GSHARE_EN
  // History 1 -> 10 -> 101; pc 0x40 base 0x10 XORs to 0x11, 0x12, 0x15.
  task automatic test_gshare();
    logic       tk   [3];
    logic [5:0] expi [3];
    tk[0] = 1'b1; tk[1] = 1'b0; tk[2] = 1'b1;
    expi[0] = 6'h11; expi[1] = 6'h12; expi[2] = 6'h15;
    do_reset();
    pred_pc = 32'h0000_0040;
    upd_idx = 6'h3F;
    upd_pred = 1'b0;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1;
      upd_taken = tk[i];
      step();
      upd_valid = 1'b0;
      #1;
      checks++;
      if (pred_idx !== expi[i]) begin
        errors++;
        $display("FAIL gshare_idx step%0d: got %h expected %h", i, pred_idx, expi[i]);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    pred_pc = '0;
    upd_valid = 1'b0;
    upd_idx = '0;
    upd_taken = 1'b0;
    upd_pred = 1'b0;
    test_reset();
    test_saturate_up();
    test_saturate_down();
    test_same_cycle();
    test_mispredict();
    test_no_update();
    test_reset_discard();
`ifdef BP_GSHARE_EN
    test_gshare();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
